// File: rtl/pwm_pkg.sv
// Shared definitions for the LED PWM duty sequencer: FSM state encoding,
// default duty width, full-scale duty helper and key bit positions.
// Latency: n/a (definitions only). Backpressure: n/a.
package pwm_pkg;

    typedef enum logic [2:0] {
        MANUAL    = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } state_t;

    localparam int DUTY_W_DEF = 10;

    localparam int KEY_UP = 0;
    localparam int KEY_DN = 1;

    // Full-scale duty value for a given compare width.
    function automatic int duty_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchronizer, stable-level debouncer, rising-edge press pulse.
// Latency: press pulses DEBOUNCE_CYC+2 cycles after a clean raw rise.
// Backpressure: none; press is a one-cycle pulse and is never held.
//
// Ports: clk, rst_n (async active-low), key_raw (raw button, active-high),
//        press (one-cycle pulse on each accepted rising level).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The counter only runs while the synced level disagrees with the
    // accepted level; any bounce back to the accepted level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// LED duty sequencer: manual key stepping or auto breathe FSM, duty applied at period end.
// Latency: duty follows pending one cycle after a period_end pulse.
// Backpressure: none; new targets wait in pending until the next period_end.
//
// Ports: clk, rst_n (async active-low), key[1:0] (raw up/down buttons),
//        mode_auto (async level, 1 = breathe), period_end (last cycle of PWM period),
//        duty (compare value), duty_upd (duty changed pulse), state (FSM debug).
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_W       = DUTY_W_DEF,
    parameter int DUTY_STEP    = 8,
    parameter int STEP_DIV     = 32768,
    parameter int HOLD_TICKS   = 64,
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        key,
    input  logic              mode_auto,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [2:0]        state
);

    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [DUTY_W-1:0] DMAX   = DUTY_W'(duty_max(DUTY_W));
    localparam logic [DUTY_W:0]   STEP_X = (DUTY_W + 1)'(DUTY_STEP);

    logic [1:0]        mode_sync;
    logic              mode_s;
    logic              up_evt;
    logic              dn_evt;
    state_t            state_q;
    state_t            state_nxt;
    logic [DUTY_W-1:0] pending;
    logic [DUTY_W-1:0] pending_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tick;
    logic              hold_done;
    logic [DUTY_W:0]   sum_x;
    logic [DUTY_W:0]   diff_x;
    logic [DUTY_W-1:0] inc_val;
    logic [DUTY_W-1:0] dec_val;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key[KEY_UP]),
        .press   (up_evt)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key[KEY_DN]),
        .press   (dn_evt)
    );

    assign mode_s = mode_sync[1];
    assign state  = state_q;

    // One extra bit catches overflow (sum) and borrow (difference), so the
    // clamp is simply a test of the top bit.
    assign sum_x   = {1'b0, pending} + STEP_X;
    assign diff_x  = {1'b0, pending} - STEP_X;
    assign inc_val = sum_x[DUTY_W]  ? DMAX : sum_x[DUTY_W-1:0];
    assign dec_val = diff_x[DUTY_W] ? '0   : diff_x[DUTY_W-1:0];

    assign tick      = (state_q != MANUAL) && (tick_cnt == TICK_W'(STEP_DIV - 1));
    assign hold_done = tick && (hold_cnt == HOLD_W'(HOLD_TICKS - 1));

    // Leaving auto mode takes priority over a tick landing on the same cycle.
    always_comb begin
        state_nxt   = state_q;
        pending_nxt = pending;
        case (state_q)
            MANUAL: begin
                if (mode_s) begin
                    state_nxt = (pending == DMAX) ? HOLD_HI : RAMP_UP;
                end else if (up_evt && !dn_evt) begin
                    pending_nxt = inc_val;
                end else if (dn_evt && !up_evt) begin
                    pending_nxt = dec_val;
                end
            end
            RAMP_UP: begin
                if (!mode_s) begin
                    state_nxt = MANUAL;
                end else if (tick) begin
                    pending_nxt = inc_val;
                    if (inc_val == DMAX) state_nxt = HOLD_HI;
                end
            end
            HOLD_HI: begin
                if (!mode_s)        state_nxt = MANUAL;
                else if (hold_done) state_nxt = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                if (!mode_s) begin
                    state_nxt = MANUAL;
                end else if (tick) begin
                    pending_nxt = dec_val;
                    if (dec_val == '0) state_nxt = HOLD_LO;
                end
            end
            HOLD_LO: begin
                if (!mode_s)        state_nxt = MANUAL;
                else if (hold_done) state_nxt = RAMP_UP;
            end
            default: state_nxt = MANUAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync <= '0;
            state_q   <= MANUAL;
            pending   <= '0;
            tick_cnt  <= '0;
            hold_cnt  <= '0;
        end else begin
            mode_sync <= {mode_sync[0], mode_auto};
            state_q   <= state_nxt;
            pending   <= pending_nxt;

            // Both counters restart on every state entry, so the first tick
            // of a new state always lands a full STEP_DIV cycles later.
            if (state_q == MANUAL || state_nxt != state_q || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            if (state_nxt != state_q) begin
                hold_cnt <= '0;
            end else if (tick && (state_q == HOLD_HI || state_q == HOLD_LO)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // duty only moves on a period boundary so no PWM period is cut short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty     <= '0;
            duty_upd <= 1'b0;
        end else if (period_end) begin
            duty     <= pending;
            duty_upd <= (pending != duty);
        end else begin
            duty_upd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
module tb_pwm_duty_sequencer;

    localparam int DW   = 10;
    localparam int STEP = 8;
    localparam int SDIV = 8;
    localparam int HOLD = 2;
    localparam int DEB  = 16;
    localparam int DMAX = 1023;
    localparam int NS   = 600;

    localparam int S_MAN = 0;
    localparam int S_UP  = 1;
    localparam int S_HI  = 2;
    localparam int S_DN  = 3;
    localparam int S_LO  = 4;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic [1:0]    key        = 2'b00;
    logic          mode_auto  = 1'b0;
    logic          period_end = 1'b0;
    logic [DW-1:0] duty;
    logic          duty_upd;
    logic [2:0]    state;

    pwm_duty_sequencer #(
        .DUTY_W       (DW),
        .DUTY_STEP    (STEP),
        .STEP_DIV     (SDIV),
        .HOLD_TICKS   (HOLD),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .mode_auto  (mode_auto),
        .period_end (period_end),
        .duty       (duty),
        .duty_upd   (duty_upd),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int exp_q[$];
    int model_duty = 0;
    int mp_old = 0, mp_new = 0, mp_t = 0;
    bit auto_model = 1'b0;
    int E = 0;
    int sched_p[NS];
    int sched_s[NS];
    int obs_max, obs_min_after_peak, state_seen;

    bit            mon_en      = 1'b1;
    logic [DW-1:0] duty_before = '0;
    logic          pe_at_edge  = 1'b0;
    int            mon_e;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT flags a duty update.
    always @(posedge clk) begin
        duty_before <= duty;
        pe_at_edge  <= period_end;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (duty_upd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_duty_upd: duty=%0d, no update expected (cycle %0d)", duty, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("duty_on_upd", int'(duty), mon_e);
                end
            end
            if (duty != duty_before)
                chk("duty_change_needs_period_end", int'(pe_at_edge), 1);
            if (duty_upd || (duty != duty_before))
                chk("upd_matches_change", int'(duty_upd), int'(duty != duty_before));
        end
    end

    // Pending value the DUT should hold during cycle c.
    function automatic int pending_at(input int c);
        int k;
        if (auto_model) begin
            k = (c - E) / SDIV;
            if (k < 0)  k = 0;
            if (k >= NS) k = NS - 1;
            return sched_p[k];
        end
        return (c >= mp_t) ? mp_new : mp_old;
    endfunction

    function automatic int state_at(input int c);
        int k;
        k = (c - E) / SDIV;
        if (k < 0)  k = 0;
        if (k >= NS) k = NS - 1;
        return sched_s[k];
    endfunction

    // Breathe trajectory per ramp tick: triangle with flat holds.
    task automatic build_sched(input int p0);
        int p, s, hc;
        p  = p0;
        s  = (p0 == DMAX) ? S_HI : S_UP;
        hc = 0;
        sched_p[0] = p;
        sched_s[0] = s;
        for (int k = 1; k < NS; k++) begin
            case (s)
                S_UP: begin
                    p = (p + STEP > DMAX) ? DMAX : p + STEP;
                    if (p == DMAX) begin s = S_HI; hc = 0; end
                end
                S_HI: begin
                    hc++;
                    if (hc == HOLD) begin s = S_DN; hc = 0; end
                end
                S_DN: begin
                    p = (p < STEP) ? 0 : p - STEP;
                    if (p == 0) begin s = S_LO; hc = 0; end
                end
                default: begin
                    hc++;
                    if (hc == HOLD) begin s = S_UP; hc = 0; end
                end
            endcase
            sched_p[k] = p;
            sched_s[k] = s;
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        period_end = 1'b0;
    endtask

    task automatic fire_pe();
        int e;
        period_end = 1'b1;
        e = pending_at(cyc);
        if (e != model_duty) begin
            exp_q.push_back(e);
            model_duty = e;
        end
        nxt();
        chk("duty_after_period_end", int'(duty), model_duty);
    endtask

    // Hold keys long enough to debounce both edges; optionally fire
    // period_end at offset pe_off and the cycle after it.
    task automatic press(input logic [1:0] k, input int pe_off);
        int t;
        t = cyc;
        key = k;
        mp_old = mp_new;
        if (k == 2'b01)      mp_new = (mp_new + STEP > DMAX) ? DMAX : mp_new + STEP;
        else if (k == 2'b10) mp_new = (mp_new < STEP) ? 0 : mp_new - STEP;
        mp_t = t + 3 + DEB;
        while (cyc < t + DEB + 6) begin
            if (pe_off >= 0 && cyc == t + pe_off) begin
                fire_pe();
                fire_pe();
            end else begin
                nxt();
            end
        end
        key = 2'b00;
        repeat (DEB + 6) nxt();
    endtask

    task automatic run_auto(input int drop_tick);
        int a, n, dk, target, a2;
        build_sched(mp_new);
        a = cyc;
        mode_auto = 1'b1;
        n = 0;
        while (state == 3'(S_MAN) && n < 12) begin
            nxt();
            n++;
        end
        chk("auto_entry_latency", cyc - a, 3);
        chk("auto_entry_state", int'(state), sched_s[0]);
        E = a + 3;
        auto_model = 1'b1;
        dk = drop_tick;
        if (drop_tick < 0) begin
            dk = 5;
            for (int k = 0; k < NS; k++) begin
                if (sched_s[k] == S_DN && sched_p[k] <= 520) begin
                    dk = k;
                    break;
                end
            end
        end
        target = E + dk * SDIV + int'($urandom_range(0, SDIV - 1));
        obs_max = 0;
        obs_min_after_peak = DMAX;
        state_seen = 0;
        while (cyc + 14 < target) begin
            repeat ($urandom_range(2, 11)) nxt();
            chk("auto_state", int'(state), state_at(cyc));
            state_seen = state_seen | (1 << int'(state));
            fire_pe();
            if (int'(duty) > obs_max) obs_max = int'(duty);
            if (obs_max == DMAX && int'(duty) < obs_min_after_peak) obs_min_after_peak = int'(duty);
        end
        while (cyc < target) nxt();
        a2 = cyc;
        mode_auto = 1'b0;
        nxt();
        nxt();
        chk("state_before_drop_lands", int'(state), state_at(a2 + 2));
        mp_new = pending_at(a2 + 2);
        mp_old = mp_new;
        mp_t = 0;
        auto_model = 1'b0;
        nxt();
        chk("state_manual_after_drop", int'(state), S_MAN);
        fire_pe();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_duty", int'(duty), 0);
        chk("rst_duty_upd", int'(duty_upd), 0);
        chk("rst_state", int'(state), S_MAN);
        rst_n = 1'b1;
        nxt();

        // Short glitch is rejected; down at zero stays at zero.
        key = 2'b01;
        repeat (3) nxt();
        key = 2'b00;
        repeat (DEB + 8) nxt();
        fire_pe();
        press(2'b10, -1);
        fire_pe();

        // Manual stepping: three ups, then a random mix.
        repeat (3) begin
            press(2'b01, -1);
            fire_pe();
        end
        for (int i = 0; i < 12; i++) begin
            press(2'($urandom_range(1, 3)), -1);
            if ($urandom_range(0, 1) == 1) fire_pe();
        end
        fire_pe();
        n = 0;
        while (mp_new != 0 && n < 100) begin
            press(2'b10, -1);
            n++;
        end
        fire_pe();

        // Full breathe cycle from zero, dropping out on the second ramp-up.
        run_auto(270);
        chk("peak_duty", obs_max, DMAX);
        chk("trough_after_peak", obs_min_after_peak, 0);
        chk("auto_states_visited", state_seen & 5'b11110, 5'b11110);

        // Drop out midway down the ramp; keys work again afterwards.
        run_auto(-1);
        press(2'b01, -1);
        fire_pe();

        // Clamp at both ends and simultaneous up+down.
        n = 0;
        while (mp_new != 0 && n < 200) begin
            press(2'b10, -1);
            n++;
        end
        fire_pe();
        for (int i = 0; i < 127; i++) begin
            press(2'b01, -1);
            if (i % 16 == 15) fire_pe();
        end
        fire_pe();
        press(2'b01, -1);
        fire_pe();
        press(2'b01, -1);
        fire_pe();
        press(2'b11, -1);
        fire_pe();

        // Auto entry at full scale goes straight to the high hold.
        run_auto(3);

        // period_end coinciding with a pending update transfers the old value.
        fire_pe();
        press(2'b10, DEB + 2);
        fire_pe();

        // Asynchronous reset in the middle of a ramp.
        mode_auto = 1'b1;
        repeat (6) nxt();
        chk("pre_reset_state", int'(state), S_UP);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_duty", int'(duty), 0);
        chk("async_rst_state", int'(state), S_MAN);
        chk("async_rst_duty_upd", int'(duty_upd), 0);
        mode_auto = 1'b0;
        exp_q.delete();
        model_duty = 0;
        mp_old = 0;
        mp_new = 0;
        mp_t = 0;
        auto_model = 1'b0;
        repeat (3) nxt();
        rst_n = 1'b1;
        nxt();
        nxt();
        mon_en = 1'b1;
        fire_pe();
        repeat (5) nxt();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
